// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single fixed-latency memory port.
// Port 0 is a read-only fetch port; port 1 handles loads and stores.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 9,
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [XLEN-1:0]       rsp0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [XLEN-1:0]       req1_wdata,
    input  logic [XLEN/8-1:0]     req1_be,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [XLEN-1:0]       rsp1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [XLEN/8-1:0]     mem_be,
    input  logic [XLEN-1:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic [3:0] lat_cnt;
    logic       last_grant;
    logic       port;
    logic       store;
    logic       grant;
    logic       accept;

    // grant = 1 selects port 1; on a tie the port not served last wins
    assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            last_grant <= 1'b1;
            port       <= 1'b0;
            store      <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        port       <= grant;
                        last_grant <= grant;
                        store      <= grant & req1_we;
                        mem_en     <= 1'b1;
                        mem_we     <= grant & req1_we;
                        mem_addr   <= grant ? req1_addr : req0_addr;
                        mem_wdata  <= grant ? req1_wdata : '0;
                        mem_be     <= grant ? req1_be : '1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    lat_cnt <= 4'(MEM_LATENCY);
                    state   <= WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    // Last wait cycle: memory data is valid on mem_rdata now
                    if (lat_cnt == 4'd1) begin
                        if (port) begin
                            rsp1_valid <= 1'b1;
                            rsp1_rdata <= store ? '0 : mem_rdata;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 and 4) share random stimulus
// and are checked every cycle against a transaction-timing model, plus directed cases.
module tb_mem_port_arbiter;
    localparam int AW = 9;
    localparam int XL = 32;
    localparam int BW = XL / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic v0 = 1'b0;
    logic [AW-1:0] a0 = '0;
    logic v1 = 1'b0;
    logic we1 = 1'b0;
    logic [AW-1:0] a1 = '0;
    logic [XL-1:0] wd1 = '0;
    logic [BW-1:0] be1 = '0;
    logic [XL-1:0] mrd = '0;

    logic          r0 [2];
    logic          r1 [2];
    logic          rv0 [2];
    logic          rv1 [2];
    logic          men [2];
    logic          mwe [2];
    logic [XL-1:0] rd0 [2];
    logic [XL-1:0] rd1 [2];
    logic [XL-1:0] mwd [2];
    logic [AW-1:0] mad [2];
    logic [BW-1:0] mbe [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .XLEN(XL), .MEM_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_addr(a0), .req0_ready(r0[0]),
        .rsp0_valid(rv0[0]), .rsp0_rdata(rd0[0]),
        .req1_valid(v1), .req1_we(we1), .req1_addr(a1), .req1_wdata(wd1), .req1_be(be1),
        .req1_ready(r1[0]), .rsp1_valid(rv1[0]), .rsp1_rdata(rd1[0]),
        .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(mad[0]), .mem_wdata(mwd[0]),
        .mem_be(mbe[0]), .mem_rdata(mrd)
    );

    mem_port_arbiter #(.ADDR_WIDTH(AW), .XLEN(XL), .MEM_LATENCY(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_addr(a0), .req0_ready(r0[1]),
        .rsp0_valid(rv0[1]), .rsp0_rdata(rd0[1]),
        .req1_valid(v1), .req1_we(we1), .req1_addr(a1), .req1_wdata(wd1), .req1_be(be1),
        .req1_ready(r1[1]), .rsp1_valid(rv1[1]), .rsp1_rdata(rd1[1]),
        .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(mad[1]), .mem_wdata(mwd[1]),
        .mem_be(mbe[1]), .mem_rdata(mrd)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Model: a transaction accepted in cycle t occupies the port until cycle t+L+3,
    // drives memory in cycle t+1 and responds in cycle t+2+L with the data seen in t+1+L.
    int            cyc = 0;
    logic [XL-1:0] hist [64];
    int            next_free [2];
    bit            last_g [2];
    bit            act [2];
    int            tt [2];
    bit            tport [2];
    bit            twe [2];
    logic [AW-1:0] h_addr [2];
    logic [XL-1:0] h_wdata [2];
    logic [BW-1:0] h_be [2];
    logic [XL-1:0] last_rd0 [2];
    logic [XL-1:0] last_rd1 [2];

    task automatic model_check(input int k);
        bit free, g, e_r0, e_r1, e_en, e_we, e_v0, e_v1;
        string s;
        e_r0 = 0; e_r1 = 0; e_en = 0; e_we = 0; e_v0 = 0; e_v1 = 0;
        if (!rst_n) begin
            next_free[k] = 0; last_g[k] = 1; act[k] = 0;
            h_addr[k] = '0; h_wdata[k] = '0; h_be[k] = '0;
            last_rd0[k] = '0; last_rd1[k] = '0;
        end else begin
            free = (cyc >= next_free[k]);
            g    = (v0 && v1) ? !last_g[k] : v1;
            e_r0 = free && v0 && !g;
            e_r1 = free && v1 && g;
            e_en = act[k] && (cyc == tt[k] + 1);
            e_we = e_en && twe[k];
            if (act[k] && (cyc == tt[k] + 2 + lat(k))) begin
                if (tport[k]) begin
                    e_v1 = 1;
                    last_rd1[k] = twe[k] ? '0 : hist[(tt[k] + 1 + lat(k)) % 64];
                end else begin
                    e_v0 = 1;
                    last_rd0[k] = hist[(tt[k] + 1 + lat(k)) % 64];
                end
                act[k] = 0;
            end
        end
        s = $sformatf("[dut%0d c%0d]", k, cyc);
        chk({"req0_ready", s}, r0[k], e_r0);
        chk({"req1_ready", s}, r1[k], e_r1);
        chk({"mem_en", s}, men[k], e_en);
        chk({"mem_we", s}, mwe[k], e_we);
        chk({"mem_addr", s}, mad[k], h_addr[k]);
        chk({"mem_wdata", s}, mwd[k], h_wdata[k]);
        chk({"mem_be", s}, mbe[k], h_be[k]);
        chk({"rsp0_valid", s}, rv0[k], e_v0);
        chk({"rsp1_valid", s}, rv1[k], e_v1);
        chk({"rsp0_rdata", s}, rd0[k], last_rd0[k]);
        chk({"rsp1_rdata", s}, rd1[k], last_rd1[k]);
        if (rst_n && (e_r0 || e_r1)) begin
            act[k]       = 1;
            tt[k]        = cyc;
            tport[k]     = e_r1;
            twe[k]       = e_r1 && we1;
            h_addr[k]    = e_r1 ? a1 : a0;
            h_wdata[k]   = e_r1 ? wd1 : '0;
            h_be[k]      = e_r1 ? be1 : '1;
            next_free[k] = cyc + lat(k) + 3;
            last_g[k]    = e_r1;
        end
    endtask

    always @(negedge clk) begin
        hist[cyc % 64] = mrd;
        model_check(0);
        model_check(1);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        v0 = 0; v1 = 0; we1 = 0;
        repeat (n) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    int  ord [8];
    int  n;
    int  cnt;
    bit  seen;
    bit  took0, took1;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Single fetch; latency 1 on dut_a, latency 4 on dut_b
        tick(); v0 = 1; a0 = 9'h010;
        look(); chk("fetch ready a", r0[0], 1); chk("fetch ready b", r0[1], 1);
        tick(); a0 = 9'h020;
        look(); chk("fetch en a", men[0], 1); chk("fetch addr a", mad[0], 9'h010);
        chk("fetch we a", mwe[0], 0); chk("fetch en b", men[1], 1); chk("busy ready b1", r0[1], 0);
        tick(); mrd = 32'h00A00093;
        look(); chk("fetch early rsp a", rv0[0], 0); chk("busy ready b2", r0[1], 0);
        tick(); mrd = 32'h5A5A0001;
        look(); chk("fetch rsp a", rv0[0], 1); chk("fetch data a", rd0[0], 32'h00A00093);
        chk("busy ready b3", r0[1], 0);
        tick();
        look(); chk("fetch rsp pulse a", rv0[0], 0); chk("busy ready b4", r0[1], 0);
        tick(); mrd = 32'h12345678;
        look(); chk("early rsp b", rv0[1], 0); chk("busy ready b5", r0[1], 0);
        tick(); mrd = 32'h0BADF00D;
        look(); chk("lat4 rsp b", rv0[1], 1); chk("lat4 data b", rd0[1], 32'h12345678);
        chk("busy ready b6", r0[1], 0);
        drain(14);

        // Store on port 1
        tick(); v1 = 1; we1 = 1; a1 = 9'h1FF; wd1 = 32'hDEADBEEF; be1 = 4'b0011;
        look(); chk("store ready a", r1[0], 1);
        tick(); v1 = 0; we1 = 0;
        look(); chk("store en", men[0], 1); chk("store we", mwe[0], 1); chk("store addr", mad[0], 9'h1FF);
        chk("store wdata", mwd[0], 32'hDEADBEEF); chk("store be", mbe[0], 4'b0011);
        tick(); mrd = 32'hFFFF0000;
        look(); chk("store en off", men[0], 0); chk("store addr hold", mad[0], 9'h1FF);
        tick();
        look(); chk("store rsp", rv1[0], 1); chk("store rdata", rd1[0], 0);
        drain(14);

        // Reset, then sustained contention from both ports
        tick(); rst_n = 0;
        look(); chk("reset addr", mad[0], 0); chk("reset wdata", mwd[0], 0);
        chk("reset be", mbe[0], 0); chk("reset rd1", rd1[0], 0);
        tick(); rst_n = 1; v0 = 1; v1 = 1; a0 = AW'($urandom); a1 = AW'($urandom); we1 = 0;
        n = 0;
        for (int i = 0; i < 40 && n < 8; i++) begin
            look();
            took0 = r0[0]; took1 = r1[0];
            if (took0) begin ord[n] = 0; n++; end
            else if (took1) begin ord[n] = 1; n++; end
            tick();
            if (took0) a0 = AW'($urandom);
            if (took1) begin a1 = AW'($urandom); we1 = 1'($urandom); wd1 = $urandom; be1 = BW'($urandom); end
            mrd = $urandom;
        end
        chk("tie grant count", n, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("tie grant %0d", i), ord[i], i % 2);
        drain(14);

        // Reset in the middle of a latency-4 load
        tick(); v0 = 1; a0 = 9'h055;
        look(); chk("rst load ready b", r0[1], 1);
        tick(); v0 = 0;
        tick(); rst_n = 0;
        look(); chk("rst en b", men[1], 0); chk("rst addr b", mad[1], 0);
        chk("rst be b", mbe[1], 0); chk("rst rsp b", rv0[1], 0); chk("rst rd0 b", rd0[1], 0);
        tick(); rst_n = 1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            look(); if (rv0[1]) cnt++;
            tick();
        end
        chk("no rsp after reset", cnt, 0);
        v1 = 1; we1 = 0; a1 = 9'h0AA; mrd = $urandom;
        look(); chk("post reset ready", r1[1], 1);
        tick(); v1 = 0;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            look(); if (rv1[1]) seen = 1;
            tick();
        end
        chk("post reset served", seen, 1);
        drain(14);

        // Port 1 pulses valid while port 0 is waiting on memory
        tick(); v0 = 1; a0 = 9'h033;
        tick(); v0 = 0;
        tick();
        tick(); v1 = 1; we1 = 1; a1 = 9'h0F0;
        look(); chk("withdrawn ready b", r1[1], 0); chk("withdrawn ready a", r1[0], 0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(); v1 = 0; we1 = 0;
            look(); if (men[1] || rv1[1] || men[0] || rv1[0]) cnt++;
        end
        chk("withdrawn no access", cnt, 0);
        drain(14);

        // Random traffic with occasional withdrawal and reset
        took0 = 0; took1 = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 249) == 0) rst_n = 0;
            mrd = $urandom;
            if (!v0 || took0) begin
                v0 = ($urandom_range(0, 9) < 5); a0 = AW'($urandom);
            end else if ($urandom_range(0, 19) == 0) v0 = 0;
            if (!v1 || took1) begin
                v1 = ($urandom_range(0, 9) < 5); we1 = 1'($urandom); a1 = AW'($urandom);
                wd1 = $urandom; be1 = BW'($urandom);
            end else if ($urandom_range(0, 19) == 0) v1 = 0;
            look();
            took0 = r0[0]; took1 = r1[0];
        end
        drain(14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, word address width (address_t).
REQ-002 SHALL have parameter XLEN, default 32, data width (word_t).
REQ-003 SHALL have parameter MEM_LATENCY, default 1, cycles from the mem_en cycle to mem_rdata valid; legal range 1..15.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req0_valid  in  1  instruction-fetch read request.
REQ-007 req0_addr  in  ADDR_WIDTH  fetch word address.
REQ-008 req0_ready  out  1  fetch request accepted this cycle.
REQ-009 rsp0_valid  out  1  fetch response valid (one-cycle pulse).
REQ-010 rsp0_rdata  out  XLEN  fetch read data.
REQ-011 req1_valid  in  1  data-port request.
REQ-012 req1_we  in  1  1 = store, 0 = load.
REQ-013 req1_addr  in  ADDR_WIDTH  data word address.
REQ-014 req1_wdata  in  XLEN  store data.
REQ-015 req1_be  in  XLEN/8  store byte enables.
REQ-016 req1_ready  out  1  data request accepted this cycle.
REQ-017 rsp1_valid  out  1  data response/store acknowledge (one-cycle pulse).
REQ-018 rsp1_rdata  out  XLEN  load data; 0 for stores.
REQ-019 mem_en, mem_we  out  1 each  memory access strobe and write enable.
REQ-020 mem_addr  out  ADDR_WIDTH; mem_wdata  out  XLEN; mem_be  out  XLEN/8; mem_rdata  in  XLEN.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; the reset state SHALL be IDLE.
REQ-022 IDLE: reqN_ready SHALL be asserted only for the granted port, only when that port's valid is high, and only in IDLE; ready is 0 in every other state.
REQ-023 Arbitration SHALL be round-robin: with both valid, grant the port not granted last; with one valid, grant that port; last_grant SHALL reset to port 1, so port 0 wins the first tie.
REQ-024 On acceptance (valid&&ready at edge t), the block SHALL latch port, addr, we, wdata, and be (forced to 0 for port 0, all-ones be), and go to ISSUE.
REQ-025 ISSUE (cycle t+1): mem_en=1 for exactly one cycle, with mem_we/addr/wdata/be from the latched values; the block SHALL then go to WAIT with a latency counter loaded to MEM_LATENCY.
REQ-026 WAIT: the block SHALL decrement the counter each cycle and, at the edge ending cycle t+1+MEM_LATENCY, capture mem_rdata (loads) or 0 (stores) and go to RESP.
REQ-027 RESP (cycle t+2+MEM_LATENCY): rspN_valid=1 for exactly one cycle on the latched port, with rspN_rdata = captured data; the block SHALL then go to IDLE.
REQ-028 The other port's rsp_valid SHALL stay 0; rsp_rdata SHALL hold its last value when not valid.
REQ-029 Requesters SHALL hold valid and payload stable until ready; the arbiter never drops or reorders a request, and at most one transaction is outstanding.
REQ-030 mem_en/mem_we SHALL be 0 outside ISSUE; mem_addr/wdata/be hold their latched values.
REQ-031 Throughput: one transaction per MEM_LATENCY+3 cycles; back-to-back contention SHALL alternate ports strictly.
REQ-032 A request deasserted while not granted SHALL cause no memory access.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, counter=0, last_grant=1, and set all outputs (ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be) to 0.
REQ-034 Reset during ISSUE/WAIT/RESP SHALL abort the transaction with no rsp_valid pulse afterwards; the first post-reset request is arbitrated fresh.

Verification
REQ-035 Single fetch, MEM_LATENCY=1: req0 addr 0x010 accepted at cycle 0 -> mem_en=1, mem_we=0, addr 0x010 in cycle 1; memory returns 0x00A00093 in cycle 2; rsp0_valid=1 with 0x00A00093 in cycle 3 only.
REQ-036 Store on port 1: we=1, addr 0x1FF, wdata 0xDEADBEEF, be 4'b0011 -> one mem_en cycle with exactly those values; rsp1_valid pulses with rdata 0.
REQ-037 Tie after reset: both valid at cycle 0 -> port 0 granted first, port 1 accepted at the next IDLE; 4 back-to-back contending pairs give grant order 0,1,0,1,0,1,0,1.
REQ-038 MEM_LATENCY=4: accept at cycle 0 -> mem_en in cycle 1, rdata captured end of cycle 5, rsp_valid in cycle 6; ready=0 in cycles 1-6.
REQ-039 Reset mid-WAIT: assert rst_n=0 in cycle 2 of a MEM_LATENCY=4 load -> all outputs 0 immediately, no rsp_valid after release, next request served normally.
REQ-040 Withdrawn request: req1_valid pulses for one cycle while port 0 is in WAIT -> no port-1 mem_en, no rsp1_valid.
